// File: rtl/cu_window_feeder.sv
// Raster-order pixel feeder for cu_engine: buffers two prior rows and emits one
// 3-pixel vertical column per accepted pixel, with the per-row PE-enable ramp.
module cu_window_feeder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [3*DATA_W-1:0]   data_out,
  output logic [8:0]            pe_en_ctrl,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];

  logic       accept;
  logic       col_last;
  logic       frame_last;
  logic       emit;
  logic [8:0] pe_next;

  assign busy       = (state != IDLE);
  assign in_ready   = busy;
  assign accept     = in_valid && in_ready;
  assign col_last   = (col == COL_LAST);
  assign frame_last = col_last && (row == ROW_LAST);
  assign emit       = accept && (state == STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        if (accept && col_last && (row == ROW_ONE)) state_next = STREAM;
      end
      STREAM: begin
        if (accept && frame_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ramp depends only on the column of the pixel being accepted.
  always_comb begin
    pe_next = 9'h1FF;
    if (col == '0) begin
      pe_next = 9'h007;
    end else if (col == CW'(1)) begin
      pe_next = 9'h03F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      pe_en_ctrl <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= emit && frame_last;
      if (emit) begin
        data_out   <= {in_data, lb1[col], lb0[col]};
        pe_en_ctrl <= pe_next;
      end else begin
        data_out   <= '0;
        pe_en_ctrl <= '0;
      end

      if (state == IDLE) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Line buffers hold no reset; reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= in_data;
    end
  end

endmodule
